// File: rtl/fwd_hazard_unit_if.sv
// ID-side issue/operand bus and register-file write port of the forwarding/hazard unit.
// master = the pipeline around the unit, slave = the unit itself.
interface fwd_hazard_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              issue_valid;
    logic              issue_we;
    logic              issue_load;
    logic [REG_W-1:0]  issue_dest;
    logic [REG_W-1:0]  src1_addr;
    logic [REG_W-1:0]  src2_addr;
    logic              src1_used;
    logic              src2_used;
    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;
    logic              flush;
    logic [DATA_W-1:0] alu_result_in;
    logic [DATA_W-1:0] mem_result_in;

    logic [DATA_W-1:0] op1_out;
    logic [DATA_W-1:0] op2_out;
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic              stall;
    logic              wb_we;
    logic [REG_W-1:0]  wb_dest;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output issue_valid, issue_we, issue_load, issue_dest,
        output src1_addr, src2_addr, src1_used, src2_used,
        output rf_data1, rf_data2, flush, alu_result_in, mem_result_in,
        input  op1_out, op2_out, fwd1_hit, fwd2_hit, stall,
        input  wb_we, wb_dest, wb_data
    );

    modport slave (
        input  issue_valid, issue_we, issue_load, issue_dest,
        input  src1_addr, src2_addr, src1_used, src2_used,
        input  rf_data1, rf_data2, flush, alu_result_in, mem_result_in,
        output op1_out, op2_out, fwd1_hit, fwd2_hit, stall,
        output wb_we, wb_dest, wb_data
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use stall and write-back driver for a STAGES-deep pipeline.
// Slot 0 is execute, slot STAGES-1 is write-back; load data appears in slot LOAD_LAT.
module fwd_hazard_unit #(
    parameter int STAGES   = 3,
    parameter int LOAD_LAT = 1,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5
) (
    input  logic             clock,
    input  logic             reset,
    fwd_hazard_unit_if.slave bus
);
    logic              slotValid [STAGES];
    logic              slotWe    [STAGES];
    logic              slotLoad  [STAGES];
    logic [REG_W-1:0]  slotDest  [STAGES];
    logic [DATA_W-1:0] slotData  [STAGES];

    logic              slotReady [STAGES];
    logic [DATA_W-1:0] slotValue [STAGES];

    logic [REG_W-1:0]  srcAddr  [2];
    logic              srcUsed  [2];
    logic [DATA_W-1:0] rfData   [2];
    logic              srcHit   [2];
    logic              srcBlock [2];
    logic [DATA_W-1:0] srcOp    [2];

    logic              stall;
    logic              admit;

    assign srcAddr[0] = bus.src1_addr;
    assign srcAddr[1] = bus.src2_addr;
    assign srcUsed[0] = bus.src1_used;
    assign srcUsed[1] = bus.src2_used;
    assign rfData[0]  = bus.rf_data1;
    assign rfData[1]  = bus.rf_data2;

    // The value a slot would hand out right now; also the value it stores when it shifts on.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            slotReady[k] = 1'b1;
            slotValue[k] = slotData[k];
            if (slotLoad[k]) begin
                if (k < LOAD_LAT) begin
                    slotReady[k] = 1'b0;
                end else if (k == LOAD_LAT) begin
                    slotValue[k] = bus.mem_result_in;
                end
            end else if (k == 0) begin
                slotValue[k] = bus.alu_result_in;
            end
        end
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            srcHit[s]   = 1'b0;
            srcBlock[s] = 1'b0;
            srcOp[s]    = rfData[s];
            // Walk oldest to youngest so the youngest writer is the one left standing.
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (srcUsed[s] && srcAddr[s] != '0 && slotValid[k] && slotWe[k]
                    && slotDest[k] == srcAddr[s]) begin
                    srcHit[s]   = slotReady[k];
                    srcBlock[s] = !slotReady[k];
                    srcOp[s]    = slotReady[k] ? slotValue[k] : rfData[s];
                end
            end
        end
    end

    assign stall = bus.issue_valid && !bus.flush && (srcBlock[0] || srcBlock[1]);
    assign admit = bus.issue_valid && !stall && !bus.flush;

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                slotValid[k] <= 1'b0;
                slotWe[k]    <= 1'b0;
                slotLoad[k]  <= 1'b0;
                slotDest[k]  <= '0;
                slotData[k]  <= '0;
            end
        end else begin
            slotValid[0] <= admit;
            slotWe[0]    <= admit && bus.issue_we;
            slotLoad[0]  <= admit && bus.issue_load;
            slotDest[0]  <= admit ? bus.issue_dest : '0;
            slotData[0]  <= '0;
            for (int k = 1; k < STAGES; k++) begin
                slotValid[k] <= slotValid[k-1];
                slotWe[k]    <= slotWe[k-1];
                slotLoad[k]  <= slotLoad[k-1];
                slotDest[k]  <= slotDest[k-1];
                slotData[k]  <= slotValue[k-1];
            end
        end
    end

    assign bus.op1_out  = srcOp[0];
    assign bus.op2_out  = srcOp[1];
    assign bus.fwd1_hit = srcHit[0];
    assign bus.fwd2_hit = srcHit[1];
    assign bus.stall    = stall;

    assign bus.wb_we   = slotValid[STAGES-1] && slotWe[STAGES-1] && slotDest[STAGES-1] != '0;
    assign bus.wb_dest = slotDest[STAGES-1];
    assign bus.wb_data = slotValue[STAGES-1];
endmodule
